// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // Digits never exceed 9 here, so the 4-bit sum cannot wrap.
    always_comb begin
        adjusted = digit;
        if (digit >= ADJ_THRESHOLD) begin
            adjusted = digit + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one adjust-and-shift step per clock,
// start/busy/done handshake, sticky overflow when DIGITS is too small.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [IN_WIDTH-1:0]           bin_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
    output logic                          overflow_o
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(IN_WIDTH - 1);

    state_t               state;
    state_t               state_next;

    logic [IN_WIDTH-1:0]  bin_sr;
    logic [BCD_W-1:0]     scratch;
    logic [BCD_W-1:0]     adjusted;
    logic [CNT_W-1:0]     cnt;
    logic                 sticky;

    logic [IN_WIDTH-1:0]  bin_shifted;
    logic [BCD_W-1:0]     scratch_shifted;
    logic                 carry_out;

    logic                 load;
    logic                 step;
    logic                 publish;

    logic [BCD_W-1:0]     bcd_q;
    logic                 ovf_q;
    logic                 done_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adjusted[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift {adjusted scratch, binary} left by one; the bit falling off the top digit is the overflow capture.
    always_comb begin
        {carry_out, scratch_shifted, bin_shifted} = {adjusted, bin_sr, 1'b0};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_STEP) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state != IDLE);
        load    = (state == IDLE) && start_i;
        step    = (state == SHIFT);
        publish = (state == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (load) begin
                bin_sr  <= bin_i;
                scratch <= '0;
                cnt     <= '0;
                sticky  <= 1'b0;
            end else if (step) begin
                bin_sr  <= bin_shifted;
                scratch <= scratch_shifted;
                cnt     <= cnt + CNT_W'(1);
                sticky  <= sticky | carry_out;
            end

            // Result registers only change on the DONE edge, so no partial value is ever visible.
            done_q <= publish;
            if (publish) begin
                bcd_q <= scratch;
                ovf_q <= sticky;
            end
        end
    end

    assign done_o     = done_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [7:0]  bin;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;

    bit          sel;
    logic        obs_busy, obs_done, obs_ovf;
    logic [11:0] obs_bcd;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bin2bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_a),
        .bin_i      (bin),
        .busy_o     (busy_a),
        .done_o     (done_a),
        .bcd_o      (bcd_a),
        .overflow_o (ovf_a)
    );

    bin2bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) u_dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_b),
        .bin_i      (bin),
        .busy_o     (busy_b),
        .done_o     (done_b),
        .bcd_o      (bcd_b),
        .overflow_o (ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        obs_busy = sel ? busy_b : busy_a;
        obs_done = sel ? done_b : done_a;
        obs_ovf  = sel ? ovf_b  : ovf_a;
        obs_bcd  = sel ? {4'h0, bcd_b} : bcd_a;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: low decimal digits of v, overflow when anything remains above them.
    function automatic void ref_conv(input int unsigned digits, input int unsigned v,
                                     output logic [11:0] bcd, output bit ovf);
        int unsigned x = v;
        bcd = '0;
        for (int unsigned i = 0; i < digits; i++) begin
            bcd[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        ovf = (x != 0);
    endfunction

    task automatic set_start(input bit v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Ticks until done is seen (bounded); reports edges waited and busy samples seen before each edge.
    task automatic wait_done(output int unsigned cyc, output int unsigned busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        do begin
            if (obs_busy) busy_cnt++;
            tick();
            cyc++;
        end while (!obs_done && cyc < 40);
    endtask

    task automatic run_conv(input bit s, input logic [7:0] v);
        logic [11:0] exp_bcd;
        bit          exp_ovf;
        int unsigned cyc, busy_cnt;
        sel = s;
        ref_conv(s ? 2 : 3, v, exp_bcd, exp_ovf);
        bin = v;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        bin = 8'($urandom_range(0, 255));
        wait_done(cyc, busy_cnt);
        check("done_seen", obs_done, 1);
        check("latency", cyc, 9);
        check("busy_cycles", busy_cnt, 9);
        check("bcd", obs_bcd, exp_bcd);
        check("overflow", obs_ovf, exp_ovf);
        tick();
        check("done_single", obs_done, 0);
        check("bcd_hold", obs_bcd, exp_bcd);
    endtask

    initial begin
        int unsigned cyc, busy_cnt, n_done;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin = '0;
        sel = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_bcd", bcd_a, 0);
        check("rst_ovf", ovf_a, 0);
        tick();
        check("idle_done", done_a, 0);

        run_conv(0, 8'd0);
        run_conv(0, 8'd225);
        run_conv(0, 8'd255);
        run_conv(0, 8'd100);

        // Start and bin_i wiggling while busy must be ignored.
        sel = 1'b0;
        bin = 8'd42;
        start_a = 1'b1;
        tick();
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 9) begin
                start_a = 1'($urandom_range(0, 1));
                bin = 8'd99;
            end else begin
                start_a = 1'b0;
            end
            tick();
            if (done_a) begin
                n_done++;
                check("ignore_bcd", bcd_a, 12'h042);
                check("ignore_ovf", ovf_a, 0);
            end
        end
        check("ignore_ndone", n_done, 1);

        // Back-to-back with start held high.
        bin = 8'd7;
        start_a = 1'b1;
        tick();
        bin = 8'd199;
        wait_done(cyc, busy_cnt);
        check("b2b_lat1", cyc, 9);
        check("b2b_bcd1", bcd_a, 12'h007);
        wait_done(cyc, busy_cnt);
        start_a = 1'b0;
        check("b2b_gap", cyc, 10);
        check("b2b_bcd2", bcd_a, 12'h199);
        tick();
        check("b2b_done_off", done_a, 0);
        check("b2b_idle", busy_a, 0);

        // Reset during the 4th SHIFT cycle aborts the conversion.
        bin = 8'd200;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_bcd", bcd_a, 0);
        check("abort_ovf", ovf_a, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a) n_done++;
        end
        check("abort_ndone", n_done, 0);
        run_conv(0, 8'd13);

        run_conv(1, 8'd123);
        run_conv(1, 8'd99);

        for (int i = 0; i < 16; i++) begin
            run_conv(0, 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 12; i++) begin
            run_conv(1, 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble binary-to-BCD converter, directly downstream of the 4-bit multiplier.
- Consumes the 8-bit product and produces decimal digits for the display driver.
- Handshake: start/busy/done.
- Does one shift-and-adjust step per clock, so there is no wide combinational divider.

Parameters:
- IN_WIDTH, 8: width of the binary input.
- DIGITS, 3: number of BCD output digits.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  request a conversion of bin_i; sampled only in IDLE.
- bin_i  input  IN_WIDTH  unsigned binary value; captured on the accepting edge.
- busy_o  output  1  high while a conversion is in progress (state != IDLE).
- done_o  output  1  one-cycle pulse; bcd_o/overflow_o are valid and updated this cycle.
- bcd_o  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- overflow_o  output  1  result did not fit in DIGITS digits; valid with bcd_o.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: state=IDLE; busy_o=0, done_o=0, bcd_o=0, overflow_o=0; internal shift/scratch registers and counter cleared. Reset has priority over every other event.
- State IDLE:
  - start_i=1 at an edge: bin_i is loaded into the binary shift register, the BCD scratch is cleared, counter=0, sticky overflow flag=0, next state SHIFT.
  - start_i=0: remain in IDLE; outputs hold.
- State SHIFT, per clock:
  - Each scratch digit >= 5 gets +3 (all digits in parallel).
  - Then the concatenation {overflow-capture, scratch, binary} shifts left by 1. The bit leaving the top digit is ORed into the sticky overflow flag.
  - Counter increments.
  - When counter reaches IN_WIDTH-1 and that step completes, next state is DONE. Exactly IN_WIDTH SHIFT cycles occur.
- State DONE, for one cycle:
  - bcd_o <= scratch, overflow_o <= sticky flag, done_o=1.
  - Next state IDLE.
- Latency: done_o is high in the cycle following edge k+IN_WIDTH+1, where edge k sampled start_i. For the default this is 9 clocks.
- Throughput: one conversion per IN_WIDTH+2 clocks, with back-to-back start.
- done_o is registered, high for exactly one cycle per accepted start, and never asserted without a prior accepted start.
- busy_o is high in SHIFT and DONE.
- start_i in SHIFT or DONE is ignored, not queued. bin_i changes after acceptance have no effect.
- bcd_o and overflow_o hold the last result until the next DONE. They are never partially updated during SHIFT.
- Reset mid-conversion aborts immediately: no done_o pulse; bcd_o and overflow_o return to 0.
- With default parameters overflow_o is always 0 (max 255). When DIGITS is too small, bcd_o holds the low DIGITS decimal digits and overflow_o=1.
- All arithmetic is unsigned. Add-3 applies to 4-bit digits only, with no carry between digits.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - BCD_DIGIT_W=4 constant;
  - ADJ_THRESHOLD=5 and ADJ_ADD=3 constants.
- Counter width is $clog2(IN_WIDTH).
- One natural sub-module, bcd_digit_adjust: combinational 4-bit in/out, output = in + 3 when in >= 5, else in. It is instantiated DIGITS times via generate.

Test Plan:
- Reset, then bin_i=0 with start_i pulsed: done_o rises exactly 9 clocks later with bcd_o=12'h000, overflow_o=0, busy_o high for 9 cycles.
- bin_i=8'd225 (15x15) with start: bcd_o=12'h225. bin_i=8'd255: bcd_o=12'h255. bin_i=8'd100: bcd_o=12'h100. All with overflow_o=0.
- Start with bin_i=8'd42; toggle start_i and change bin_i to 8'd99 during SHIFT and DONE: exactly one done_o, bcd_o=12'h042.
- Back-to-back: start held high continuously with bin_i=8'd7, then 8'd199 when accepted. done_o pulses every 10 clocks; bcd_o reads 12'h007, then 12'h199.
- Reset asserted on the 4th SHIFT cycle of bin_i=8'd200: no done_o, bcd_o=0, busy_o=0 the cycle after. A following start of 8'd13 yields 12'h013.
- DIGITS=2, bin_i=8'd123: bcd_o=8'h23, overflow_o=1. Then bin_i=8'd99: bcd_o=8'h99, overflow_o=0, so the sticky flag clears per conversion.
